// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types and constants for the BIST sequencer
package bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } bist_state_e;

  // Feedback taps for x^8+x^6+x^5+x^4+1: bits 7, 5, 4 and 3 of the shifted register
  localparam logic [7:0]  MISR_TAPS    = 8'hB8;
  localparam logic [7:0]  DEFAULT_SEED = 8'hA5;
  localparam logic [15:0] NO_FAIL      = 16'hFFFF;

  function automatic logic [7:0] misr_next(input logic [7:0] sig, input logic [7:0] din);
    return {sig[6:0], ^(sig & MISR_TAPS)} ^ din;
  endfunction

endpackage

// File: rtl/bist_lat_pipe.sv
// rtl/bist_lat_pipe.sv - valid+tag delay line matching the LFSR->ALU datapath latency
// DEPTH of 0 degenerates to a combinational pass-through.
module bist_lat_pipe #(
  parameter int DEPTH = 1,
  parameter int TAG_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      wire unused_bypass = &{1'b0, clk_i, rstn_i, flush_i};
      assign valid_o = valid_i;
      assign tag_o   = tag_i;
    end else begin : g_pipe
      logic [DEPTH-1:0] valid_q;
      logic [TAG_W-1:0] tag_q [DEPTH];

      // Only the valid bits are flushed; stale tags are harmless without them.
      always_ff @(posedge clk_i) begin
        if (!rstn_i || flush_i) begin
          valid_q <= '0;
        end else begin
          valid_q[0] <= valid_i;
          for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
        end
        tag_q[0] <= tag_i;
        for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
      end

      assign valid_o = valid_q[DEPTH-1];
      assign tag_o   = tag_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/bist_sequencer.sv
// rtl/bist_sequencer.sv - LFSR/ALU self-test run controller with compare qualification
// Optional MISR signature over ALU outputs when BIST_MISR_EN is defined.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int         N_PATTERNS = 200,
  parameter int         DUT_LAT    = 1,
  parameter logic [7:0] SEED       = DEFAULT_SEED,
  parameter int         FCNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              lfsr_load,
  output logic [7:0]        lfsr_seed,
  output logic              lfsr_step,
  input  logic              cmp_equal,
  input  logic              lfsr_stuck,
`ifdef BIST_MISR_EN
  input  logic [7:0]        alu_out,
  output logic [7:0]        signature,
`endif
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              lockup,
  output logic [FCNT_W-1:0] fail_count,
  output logic [15:0]       first_fail
);

  bist_state_e       state_q;
  logic [15:0]       pcnt_q;
  logic [2:0]        dcnt_q;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [15:0]       ffail_q, ffail_d;
  logic              lockup_q, pass_q;
  logic              flush, pipe_valid, qual;
  logic [15:0]       pipe_tag;

  assign lfsr_load  = (state_q == S_LOAD);
  assign lfsr_step  = (state_q == S_RUN);
  assign busy       = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign lfsr_seed  = SEED;
  assign pass       = pass_q;
  assign lockup     = lockup_q;
  assign fail_count = fcnt_q;
  assign first_fail = ffail_q;

  // Abort or lock-up kills every compare still in flight, including the one arriving now.
  assign flush = (busy && abort) || (lfsr_step && lfsr_stuck);
  assign qual  = pipe_valid && !flush;

  bist_lat_pipe #(.DEPTH(DUT_LAT), .TAG_W(16)) u_pipe (
    .clk_i   (clk),
    .rstn_i  (rst),
    .flush_i (flush),
    .valid_i (lfsr_step),
    .tag_i   (pcnt_q),
    .valid_o (pipe_valid),
    .tag_o   (pipe_tag)
  );

  always_comb begin
    fcnt_d  = fcnt_q;
    ffail_d = ffail_q;
    if (qual && !cmp_equal) begin
      if (fcnt_q != '1) fcnt_d = fcnt_q + FCNT_W'(1);
      if (fcnt_q == '0) ffail_d = pipe_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pcnt_q   <= '0;
      dcnt_q   <= '0;
      fcnt_q   <= '0;
      ffail_q  <= NO_FAIL;
      lockup_q <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      ffail_q <= ffail_d;
      case (state_q)
        S_IDLE: if (start) begin
          state_q  <= S_LOAD;
          fcnt_q   <= '0;
          ffail_q  <= NO_FAIL;
          lockup_q <= 1'b0;
          pass_q   <= 1'b0;
        end
        S_LOAD: begin
          pcnt_q  <= '0;
          dcnt_q  <= '0;
          state_q <= abort ? S_DONE : S_RUN;
        end
        S_RUN: begin
          // pass is resolved on entry to DONE so it is already valid during the done pulse
          if (abort || lfsr_stuck) begin
            state_q  <= S_DONE;
            lockup_q <= lfsr_stuck;
            pass_q   <= 1'b0;
          end else if (pcnt_q == 16'(N_PATTERNS - 1)) begin
            if (DUT_LAT == 0) begin
              state_q <= S_DONE;
              pass_q  <= (fcnt_d == '0);
            end else begin
              state_q <= S_DRAIN;
            end
          end else begin
            pcnt_q <= pcnt_q + 16'd1;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state_q <= S_DONE;
            pass_q  <= 1'b0;
          end else if (dcnt_q == 3'(DUT_LAT - 1)) begin
            state_q <= S_DONE;
            pass_q  <= (fcnt_d == '0);
          end else begin
            dcnt_q <= dcnt_q + 3'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef BIST_MISR_EN
  logic [7:0] sig_q;

  always_ff @(posedge clk) begin
    if (!rst || state_q == S_LOAD) sig_q <= '0;
    else if (qual)                 sig_q <= misr_next(sig_q, alu_out);
  end

  assign signature = sig_q;
`endif

endmodule

// File: tb/tb_bist_sequencer.sv
// tb/tb_bist_sequencer.sv - table-driven scoreboard bench for bist_sequencer
module tb_bist_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       abort = 1'b0;
  logic       cmp_equal = 1'b1;
  logic       lfsr_stuck = 1'b0;
  logic [2:0] start_v = '0;

  logic ld0, st0, bz0, dn0, ps0, lk0;
  logic ld1, st1, bz1, dn1, ps1, lk1;
  logic ld2, st2, bz2, dn2, ps2, lk2;
  logic [7:0]  sd0, sd1, sd2;
  logic [7:0]  fc0, fc2;
  logic [3:0]  fc1;
  logic [15:0] ff0, ff1, ff2;
`ifdef BIST_MISR_EN
  logic [7:0] alu_out = 8'h00;
  logic [7:0] sig0, sig1, sig2;
`endif

  bist_sequencer #(.N_PATTERNS(200), .DUT_LAT(1), .SEED(8'hA5), .FCNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort),
    .lfsr_load(ld0), .lfsr_seed(sd0), .lfsr_step(st0),
    .cmp_equal(cmp_equal), .lfsr_stuck(lfsr_stuck),
`ifdef BIST_MISR_EN
    .alu_out(alu_out), .signature(sig0),
`endif
    .busy(bz0), .done(dn0), .pass(ps0), .lockup(lk0), .fail_count(fc0), .first_fail(ff0)
  );

  bist_sequencer #(.N_PATTERNS(200), .DUT_LAT(1), .SEED(8'hA5), .FCNT_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort),
    .lfsr_load(ld1), .lfsr_seed(sd1), .lfsr_step(st1),
    .cmp_equal(cmp_equal), .lfsr_stuck(lfsr_stuck),
`ifdef BIST_MISR_EN
    .alu_out(alu_out), .signature(sig1),
`endif
    .busy(bz1), .done(dn1), .pass(ps1), .lockup(lk1), .fail_count(fc1), .first_fail(ff1)
  );

  bist_sequencer #(.N_PATTERNS(10), .DUT_LAT(0), .SEED(8'hA5), .FCNT_W(8)) u_dut_l0 (
    .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort),
    .lfsr_load(ld2), .lfsr_seed(sd2), .lfsr_step(st2),
    .cmp_equal(cmp_equal), .lfsr_stuck(lfsr_stuck),
`ifdef BIST_MISR_EN
    .alu_out(alu_out), .signature(sig2),
`endif
    .busy(bz2), .done(dn2), .pass(ps2), .lockup(lk2), .fail_count(fc2), .first_fail(ff2)
  );

  int cur = 0;
  logic        o_bz, o_st, o_dn, o_ps, o_lk;
  logic [7:0]  o_fc;
  logic [15:0] o_ff;

  always_comb begin
    o_bz = bz0; o_st = st0; o_dn = dn0; o_ps = ps0; o_lk = lk0; o_fc = fc0; o_ff = ff0;
    if (cur == 1) begin
      o_bz = bz1; o_st = st1; o_dn = dn1; o_ps = ps1; o_lk = lk1; o_fc = {4'h0, fc1}; o_ff = ff1;
    end else if (cur == 2) begin
      o_bz = bz2; o_st = st2; o_dn = dn2; o_ps = ps2; o_lk = lk2; o_fc = fc2; o_ff = ff2;
    end
  end

  typedef struct {
    int sel; int lat; int bad1; int bad2; int all_bad;
    int stuck_at; int abort_at; int rst_at; int restart_at;
    int exp_done; int exp_busy; int exp_steps;
    int exp_pass; int exp_lock; int exp_fcnt; int exp_ff;
  } run_t;

  run_t vecs[9];
  run_t sb_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic do_run(input int idx, input run_t v);
    int c, done_at, n_done, busy_n, step_n, tag, bound;
    run_t e;
    cur = v.sel;
    sb_q.push_back(v);
    bound = (v.exp_done < 0) ? 260 : 400;
    @(negedge clk);
    start_v[v.sel] = 1'b1;
    @(posedge clk);
    c = 0; done_at = -1; n_done = 0; busy_n = 0; step_n = 0;
    while (c < bound && n_done == 0) begin
      @(negedge clk);
      start_v = '0;
      if (c == v.restart_at) start_v[v.sel] = 1'b1;
      busy_n += int'(o_bz);
      step_n += int'(o_st);
      if (o_dn) begin
        n_done++;
        done_at = c;
      end
      tag        = c - 1 - v.lat;
      cmp_equal  = !(v.all_bad != 0 || (tag >= 0 && (tag == v.bad1 || tag == v.bad2)));
      lfsr_stuck = (v.stuck_at >= 0) && (c - 1 == v.stuck_at);
      abort      = (v.abort_at >= 0) && (c - 1 == v.abort_at);
      rst        = !((v.rst_at >= 0) && (c - 1 == v.rst_at));
      @(posedge clk);
      c++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_v = '0; cmp_equal = 1'b1; lfsr_stuck = 1'b0; abort = 1'b0; rst = 1'b1;
      busy_n += int'(o_bz);
      step_n += int'(o_st);
      n_done += int'(o_dn);
      @(posedge clk);
    end
    @(negedge clk);
    e = sb_q.pop_front();
    check($sformatf("v%0d_done_cycle", idx), done_at, e.exp_done);
    check($sformatf("v%0d_done_pulses", idx), n_done, (e.exp_done >= 0) ? 1 : 0);
    check($sformatf("v%0d_busy_cycles", idx), busy_n, e.exp_busy);
    check($sformatf("v%0d_steps", idx), step_n, e.exp_steps);
    check($sformatf("v%0d_pass", idx), int'(o_ps), e.exp_pass);
    check($sformatf("v%0d_lockup", idx), int'(o_lk), e.exp_lock);
    check($sformatf("v%0d_fail_count", idx), int'(o_fc), e.exp_fcnt);
    check($sformatf("v%0d_first_fail", idx), int'(o_ff), e.exp_ff);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nb, nd;
    //          sel lat bad1 bad2 all stk abt rst rsa  done busy steps pass lock fcnt ff
    vecs[0] = '{0, 1, -1, -1, 0, -1, -1, -1, 50, 202, 202, 200, 1, 0, 0, 'hFFFF};
    vecs[1] = '{0, 1, 17, 42, 0, -1, -1, -1, -1, 202, 202, 200, 0, 0, 2, 17};
    vecs[2] = '{0, 1, 2, -1, 0, 5, -1, -1, -1, 7, 7, 6, 0, 1, 1, 2};
    vecs[3] = '{0, 1, 17, 42, 0, -1, 100, -1, -1, 102, 102, 101, 0, 0, 2, 17};
    vecs[4] = '{0, 1, -1, -1, 0, -1, -1, -1, -1, 202, 202, 200, 1, 0, 0, 'hFFFF};
    vecs[5] = '{0, 1, 17, -1, 0, -1, -1, 50, -1, -1, 52, 51, 0, 0, 0, 'hFFFF};
    vecs[6] = '{1, 1, -1, -1, 1, -1, -1, -1, -1, 202, 202, 200, 0, 0, 15, 0};
    vecs[7] = '{2, 0, 3, -1, 0, -1, -1, -1, -1, 11, 11, 10, 0, 0, 1, 3};
    vecs[8] = '{0, 1, -1, -1, 0, 30, 30, -1, -1, 32, 32, 31, 0, 1, 0, 'hFFFF};

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(bz0), 0);
    check("rst_done", int'(dn0), 0);
    check("rst_load", int'(ld0), 0);
    check("rst_step", int'(st0), 0);
    check("rst_pass", int'(ps0), 0);
    check("rst_lockup", int'(lk0), 0);
    check("rst_fail_count", int'(fc0), 0);
    check("rst_first_fail", int'(ff0), 'hFFFF);
    check("rst_seed", int'(sd0), 'hA5);
    check("rst_first_fail_sat", int'(ff1), 'hFFFF);
    check("rst_first_fail_l0", int'(ff2), 'hFFFF);
    rst = 1'b1;

    abort = 1'b1;
    nb = 0; nd = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nb += int'(bz0);
      nd += int'(dn0);
    end
    abort = 1'b0;
    check("idle_abort_busy", nb, 0);
    check("idle_abort_done", nd, 0);

    for (int i = 0; i < 9; i++) begin
      do_run(i, vecs[i]);
`ifdef BIST_MISR_EN
      if (i == 0) check("misr_zero_sig", int'(sig0), 0);
      if (i == 6) check("misr_zero_sig_sat", int'(sig1), 0);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bist_sequencer.md
Name: bist_sequencer

Overview:
- Controller for the LFSR→ALU→reference-model self-test datapath.
- Loads the LFSR seed, steps it for a programmed number of patterns, and qualifies ALU-vs-reference compares after a fixed datapath latency.
- Counts mismatches, records the first failing pattern index, detects LFSR lock-up, and reports pass/fail.
- Sits between the test top level and the LFSR/ALU/reference instances.

Parameters:
- N_PATTERNS, 200, patterns applied per run (1..65535).
- DUT_LAT, 1, cycles from an lfsr_step pulse to a valid compare result (0..7).
- SEED, 8'hA5, LFSR seed loaded at run start; must be nonzero.
- FCNT_W, 8, fail counter width; saturates.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low
- start  in  1  start request; one-cycle pulse or level, sampled only in IDLE
- abort  in  1  terminate the current run
- lfsr_load  out  1  load seed into LFSR this cycle
- lfsr_seed  out  8  seed value; constant SEED
- lfsr_step  out  1  advance LFSR one state this cycle
- cmp_equal  in  1  ALU output equals reference model (the alu_output_equal_ref_model signal)
- lfsr_stuck  in  1  LFSR current state equals next state (the lfsr_current_equal_next signal)
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- pass  out  1  sticky result, valid after done
- lockup  out  1  sticky flag: LFSR stuck detected
- fail_count  out  FCNT_W  mismatches in the last run, saturating
- first_fail  out  16  pattern index of the first mismatch; 16'hFFFF if none

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE. All outputs 0, except first_fail=16'hFFFF. Pipeline cleared.
- States:
  - IDLE → LOAD on start.
  - LOAD: 1 cycle; lfsr_load=1. → RUN.
  - RUN: lfsr_step=1 every cycle; pattern counter pcnt increments from 0. After the step with pcnt==N_PATTERNS-1 → DRAIN.
  - DRAIN: exactly DUT_LAT cycles, no steps. If DUT_LAT==0, skip straight to DONE.
  - DONE: 1 cycle; done=1. → IDLE.
- busy=1 in LOAD, RUN and DRAIN.
- Compare qualification:
  - A valid shift register of depth DUT_LAT carries each step pulse and its pcnt tag.
  - cmp_equal is sampled only when the delayed valid is 1. Each sample where cmp_equal==0 increments fail_count (saturating at all-ones).
  - first_fail captures the tag of the first failing sample only.
  - With DUT_LAT==0, cmp_equal is sampled in the same cycle as lfsr_step.
- Lock-up: if lfsr_stuck==1 while lfsr_step==1, set lockup=1 and go directly to DONE. Remaining in-flight compares are discarded.
- pass (written in DONE) = (fail_count==0) && !lockup && !aborted.
- Abort: abort==1 in LOAD, RUN or DRAIN goes to DONE next cycle with pass=0. Counters freeze at their current values; in-flight compares are discarded. abort in IDLE is ignored.
- start while busy: ignored.
- At the LOAD entry: fail_count, first_fail, lockup and pass are cleared. Results persist through IDLE until the next start.
- Simultaneous abort and lockup: both causes are recorded; lockup=1, pass=0.
- Total run length with no abort: 1 + N_PATTERNS + DUT_LAT + 1 cycles from the LOAD cycle to DONE inclusive.

Optional Feature:
- Macro: BIST_MISR_EN.
- When defined:
  - Adds input alu_out[7:0] and output signature[7:0].
  - An 8-bit MISR (taps x^8+x^6+x^5+x^4+1) is cleared to 0 in LOAD and updates on every qualified compare: sig <= {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} ^ alu_out.
  - signature holds its value after DONE.
- When undefined: neither port exists and there is no MISR logic.

Decomposition:
- Package bist_pkg:
  - state enum (IDLE, LOAD, RUN, DRAIN, DONE)
  - MISR tap constant
  - default SEED
  - NO_FAIL = 16'hFFFF
- One sub-module, bist_lat_pipe: parameterized valid+tag delay line of depth DUT_LAT, with a flush input driven by abort/lockup.

Test Plan:
- Clean run: N_PATTERNS=200, DUT_LAT=1, cmp_equal held at 1, one start pulse → busy for 202 cycles, done pulse on the 203rd, pass=1, fail_count=0, first_fail=FFFF.
- Injected mismatches: force cmp_equal=0 for the compares tagged 17 and 42 → fail_count=2, first_fail=17, pass=0.
- Lock-up: assert lfsr_stuck at pattern 5 → DONE on the next cycle, lockup=1, pass=0, and no further lfsr_step pulses.
- Abort at pattern 100 → done one cycle later, pass=0, fail_count frozen at its value; a following start clears all results and completes with pass=1.
- Reset mid-RUN: rst=0 for one cycle at pattern 50 → IDLE next cycle, all outputs at reset values, first_fail=FFFF, no done pulse.
- Saturation and latency edge cases:
  - FCNT_W=4 with 200 mismatches → fail_count=4'hF.
  - DUT_LAT=0 → DONE immediately after the last step.
  - With BIST_MISR_EN, a constant alu_out=8'h00 gives signature=0.
